// File: rtl/io_interval_timer.sv
// io_interval_timer: memory-mapped down-counting interval timer with prescaler.
//
// Register window (offset from BASE_ADDRESS, word aligned):
//   0x00 CONTROL  [0] ENABLE  [1] AUTO_RELOAD  [2] IRQ_EN
//   0x04 COUNT    32-bit down counter
//   0x08 RELOAD   32-bit reload value for auto-reload mode
//   0x0C STATUS   [0] EXPIRED (sticky, write 1 to clear)
//   0x10 PRESCALE [15:0] tick divider, a tick every PRESCALE+1 cycles
//
// Ports:
//   clk           - clock, rising edge
//   reset         - asynchronous active-low reset
//   io_write_en   - single-cycle store strobe
//   io_read_en    - single-cycle load strobe
//   io_address    - byte address of the access
//   io_write_data - store data
//   io_read_data  - registered load data, valid the cycle after io_read_en
//   interrupt_req - level interrupt, EXPIRED & IRQ_EN
module io_interval_timer #(
  parameter logic [31:0] BASE_ADDRESS = 32'hffff0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        interrupt_req
);

  localparam logic [2:0] OFF_CONTROL  = 3'd0;
  localparam logic [2:0] OFF_COUNT    = 3'd1;
  localparam logic [2:0] OFF_RELOAD   = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  // The run state is the CONTROL.ENABLE bit itself.
  typedef enum logic {IDLE = 1'b0, RUNNING = 1'b1} state_t;

  state_t      state, state_next;
  logic        auto_reload;
  logic        irq_en;
  logic [31:0] count;
  logic [31:0] reload;
  logic [15:0] prescale;
  logic [15:0] pcnt;
  logic        expired;

  // Address decode: upper bits must match the window, word aligned only.
  logic       hit;
  logic [2:0] offset;
  assign hit    = (io_address[31:5] == BASE_ADDRESS[31:5]) && (io_address[1:0] == 2'b00);
  assign offset = io_address[4:2];

  logic wr_control, wr_count, wr_reload, wr_status, wr_prescale;
  assign wr_control  = io_write_en && hit && (offset == OFF_CONTROL);
  assign wr_count    = io_write_en && hit && (offset == OFF_COUNT);
  assign wr_reload   = io_write_en && hit && (offset == OFF_RELOAD);
  assign wr_status   = io_write_en && hit && (offset == OFF_STATUS);
  assign wr_prescale = io_write_en && hit && (offset == OFF_PRESCALE);

  logic tick, expiry;
  assign tick   = (state == RUNNING) && (pcnt == prescale);
  assign expiry = tick && (count == 32'd0);

  // Next run state: a CONTROL write beats the hardware one-shot disable.
  always_comb begin
    state_next = state;
    if (wr_control)
      state_next = state_t'(io_write_data[0]);
    else if (expiry && !auto_reload)
      state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      reload      <= '0;
      prescale    <= '0;
    end else begin
      if (wr_control) begin
        auto_reload <= io_write_data[1];
        irq_en      <= io_write_data[2];
      end
      if (wr_reload)   reload   <= io_write_data;
      if (wr_prescale) prescale <= io_write_data[15:0];
    end
  end

  // Prescaler: held at 0 while idle, restarted by any PRESCALE write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              pcnt <= '0;
    else if (wr_prescale || state == IDLE || tick) pcnt <= '0;
    else                                     pcnt <= pcnt + 16'd1;
  end

  // COUNT: software write overrides any same-cycle decrement or reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 count <= '0;
    else if (wr_count)          count <= io_write_data;
    else if (tick) begin
      if (count != 32'd0)       count <= count - 32'd1;
      else if (auto_reload)     count <= reload;
    end
  end

  // EXPIRED: set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           expired <= 1'b0;
    else if (expiry)                      expired <= 1'b1;
    else if (wr_status && io_write_data[0]) expired <= 1'b0;
  end

  // Read mux sees pre-write register values, so read+write returns old data.
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (offset)
        OFF_CONTROL:  rd_mux = {29'd0, irq_en, auto_reload, state == RUNNING};
        OFF_COUNT:    rd_mux = count;
        OFF_RELOAD:   rd_mux = reload;
        OFF_STATUS:   rd_mux = {31'd0, expired};
        OFF_PRESCALE: rd_mux = {16'd0, prescale};
        default:      rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          io_read_data <= '0;
    else if (io_read_en) io_read_data <= rd_mux;
  end

  assign interrupt_req = expired & irq_en;

endmodule

// File: tb/tb_io_interval_timer.sv
// Scoreboard bench for io_interval_timer: directed scenarios then random
// register traffic, each read checked against a cycle-level reference model.
module tb_io_interval_timer;

  localparam logic [31:0] BASE = 32'hffff0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_write_en, io_read_en;
  logic [31:0] io_address, io_write_data, io_read_data;
  logic        interrupt_req;

  always #5 clk = ~clk;

  io_interval_timer #(.BASE_ADDRESS(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .interrupt_req (interrupt_req)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic [31:0] d;
    logic        irq;
  } exp_t;
  exp_t sb[$];

  // ---------------- reference model ----------------
  bit          m_en, m_ar, m_ie, m_exp;
  logic [31:0] m_count, m_reload;
  int          m_pre, m_pdiv;

  function automatic void model_clear();
    m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
    m_count = 0; m_reload = 0; m_pre = 0; m_pdiv = 0;
  endfunction

  function automatic bit is_hit(input logic [31:0] a);
    return ((a >> 5) == (BASE >> 5)) && ((a % 4) == 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a & 32'h1f;
    if (!is_hit(a)) return 0;
    case (off)
      32'h00:  return (m_ie ? 4 : 0) + (m_ar ? 2 : 0) + (m_en ? 1 : 0);
      32'h04:  return m_count;
      32'h08:  return m_reload;
      32'h0c:  return m_exp ? 1 : 0;
      32'h10:  return m_pre;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_irq();
    return m_exp && m_ie;
  endfunction

  // One clock of behaviour, applied in rule order; later rules take priority.
  function automatic void model_step(input bit we, input logic [31:0] a, input logic [31:0] wd);
    bit          w, tick, zero;
    logic [31:0] off, c;
    bit          en, ar, ie, ex;
    int          pd;
    w    = we && is_hit(a);
    off  = a & 32'h1f;
    tick = m_en && (m_pdiv == m_pre);
    zero = (m_count == 0);
    c = m_count; en = m_en; ar = m_ar; ie = m_ie; ex = m_exp;
    if (tick) c = zero ? (m_ar ? m_reload : 0) : m_count - 1;
    if (tick && zero && !m_ar) en = 0;
    pd = (!m_en || tick) ? 0 : m_pdiv + 1;
    if (w && off == 32'h0c && wd[0]) ex = 0;
    if (tick && zero) ex = 1;
    if (w && off == 32'h04) c = wd;
    if (w && off == 32'h00) begin en = wd[0]; ar = wd[1]; ie = wd[2]; end
    if (w && off == 32'h08) m_reload = wd;
    if (w && off == 32'h10) begin m_pre = wd % 65536; pd = 0; end
    m_count = c; m_en = en; m_ar = ar; m_ie = ie; m_exp = ex; m_pdiv = pd;
  endfunction

  // ---------------- stimulus ----------------
  task automatic do_cycle(input bit we, input bit re, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    io_write_en = we; io_read_en = re; io_address = a; io_write_data = wd;
    e.d = model_read(a);
    @(posedge clk);
    model_step(we, a, wd);
    if (re) begin
      e.irq = model_irq();
      sb.push_back(e);
    end
    @(negedge clk);
    io_write_en = 0; io_read_en = 0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d); do_cycle(1, 0, BASE + off, d); endtask
  task automatic rd(input logic [31:0] off);                       do_cycle(0, 1, BASE + off, 0); endtask
  task automatic nop();                                            do_cycle(0, 0, BASE + 32'h40, 0); endtask

  task automatic rd_all();
    rd(0); rd(4); rd(8); rd(12); rd(16);
  endtask

  task automatic apply_reset();
    #2 reset = 0;
    model_clear();
    #1;
    check("reset_rdata", io_read_data, 0);
    check("reset_irq", {31'd0, interrupt_req}, 0);
    @(negedge clk) reset = 1;
  endtask

  // ---------------- monitor ----------------
  logic rd_flag;
  exp_t mon_e;
  always @(posedge clk or negedge reset)
    if (!reset) rd_flag <= 1'b0;
    else        rd_flag <= io_read_en;

  always @(negedge clk) begin
    if (rd_flag) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("rdata", io_read_data, mon_e.d);
        check("irq", {31'd0, interrupt_req}, {31'd0, mon_e.irq});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    logic [31:0] a, off, wd;
    bit we, re;
    reset = 0; io_write_en = 0; io_read_en = 0; io_address = 0; io_write_data = 0;
    model_clear();
    #3;
    check("por_rdata", io_read_data, 0);
    check("por_irq", {31'd0, interrupt_req}, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    rd_all();

    // One-shot, PRESCALE=0, COUNT=3: expiry 4 cycles after enable.
    wr(16, 0); wr(4, 3); wr(0, 5);
    k = 0;
    while (!interrupt_req && k < 20) begin nop(); k++; end
    check("oneshot_latency", k, 4);
    rd(0); rd(4); rd(12);
    wr(12, 1); rd(12);

    // Auto-reload, PRESCALE=2: COUNT 1,0,1,0 with expiry every 6 cycles.
    wr(16, 2); wr(8, 1); wr(4, 1); wr(0, 7);
    repeat (14) rd(4);
    wr(12, 1); rd(12);
    wr(0, 0); wr(12, 1); rd(12);

    // STATUS clear coincident with expiry: set wins.
    wr(16, 0); wr(4, 0); wr(0, 5);
    wr(12, 1);
    check("set_wins_irq", {31'd0, interrupt_req}, 1);
    rd(12); rd(0);
    wr(12, 1);

    // COUNT write coincident with a tick.
    wr(4, 5); wr(0, 1); wr(4, 32'h10); rd(4);
    wr(0, 0); rd(4);

    // Unmapped and out-of-window accesses.
    rd(32'h14); rd(32'h100); wr(32'h14, 32'hffffffff); wr(32'h104, 32'hffffffff);
    do_cycle(0, 1, BASE + 5, 0); do_cycle(1, 0, BASE + 6, 32'h7);
    rd_all();

    // Reset while running.
    wr(16, 3); wr(4, 5); wr(0, 5);
    repeat (4) nop();
    apply_reset();
    rd_all();
    repeat (30) nop();
    rd(12);
    check("post_reset_irq", {31'd0, interrupt_req}, 0);

    // Random register traffic.
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 9))
        7:       a = BASE + 32'h14 + 4 * $urandom_range(0, 2);
        8:       a = BASE + 4 * $urandom_range(0, 4) + $urandom_range(1, 3);
        9:       a = BASE ^ (32'd1 << $urandom_range(5, 31));
        default: a = BASE + 4 * $urandom_range(0, 4);
      endcase
      off = a & 32'h1f;
      case (off)
        32'h00:         begin wd = $urandom; wd[0] = ($urandom_range(0, 3) != 0); end
        32'h04, 32'h08: wd = $urandom_range(0, 6);
        32'h10:         wd = ($urandom & 32'hffff0000) | $urandom_range(0, 3);
        default:        wd = $urandom;
      endcase
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) apply_reset();
      do_cycle(we, re, a, wd);
    end
    rd_all();
    repeat (3) nop();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
